// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit line driver.
package usb_pkg;

    typedef enum logic [1:0] {IDLE, DATA, EOP_SE0, EOP_J} line_state_t;

    typedef enum logic [1:0] {LS_J, LS_K, LS_SE0} bus_level_t;

    localparam int USB_MAX_PKT_BITS = 128;

    // Map a bus level onto the {dp, dm} pair; anything unknown falls back to idle J.
    function automatic logic [1:0] encode_level(input bus_level_t level);
        logic [1:0] pair;
        case (level)
            LS_J:    pair = 2'b10;
            LS_K:    pair = 2'b01;
            LS_SE0:  pair = 2'b00;
            default: pair = 2'b10;
        endcase
        return pair;
    endfunction

endpackage

// File: rtl/usb_line_driver.sv
// USB line driver: NRZI stream to dp/dm with EOP insertion and idle J.
// Optional packet-length watchdog enabled by LINE_DRIVER_TIMEOUT_EN.
module usb_line_driver
    import usb_pkg::*;
#(
    parameter int EOP_SE0_BITS = 2,
    parameter int MAX_PKT_BITS = USB_MAX_PKT_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic nrzi_bit,
    input  logic tx_start,
    input  logic tx_last,
    output logic dp,
    output logic dm,
    output logic oe,
    output logic busy,
    output logic eop_done
`ifdef LINE_DRIVER_TIMEOUT_EN
    ,
    output logic timeout_err
`endif
);

    localparam int ECW = $clog2(EOP_SE0_BITS + 1);
    localparam logic [ECW-1:0] EOP_LAST = ECW'(EOP_SE0_BITS - 1);

    line_state_t    state_r;
    line_state_t    state_s;
    logic [ECW-1:0] eop_cnt;
    logic [ECW-1:0] eop_cnt_s;
    bus_level_t     level_s;
    logic           oe_s;
    logic           busy_s;
    logic           eop_done_s;
    logic           timeout_s;

`ifdef LINE_DRIVER_TIMEOUT_EN
    localparam int BCW = $clog2(MAX_PKT_BITS + 1);
    localparam logic [BCW-1:0] BIT_LIMIT = BCW'(MAX_PKT_BITS);

    logic [BCW-1:0] bit_cnt;
    logic [BCW-1:0] bit_cnt_s;
`endif

    // Next state and next line level; busy output gates acceptance so the
    // cycle after the EOP J still refuses a new packet.
    always_comb begin
        state_s    = state_r;
        eop_cnt_s  = eop_cnt;
        level_s    = LS_J;
        oe_s       = 1'b0;
        busy_s     = 1'b0;
        eop_done_s = 1'b0;
        timeout_s  = 1'b0;
`ifdef LINE_DRIVER_TIMEOUT_EN
        bit_cnt_s  = bit_cnt;
`endif
        case (state_r)
            IDLE: begin
                eop_cnt_s = {ECW{1'b0}};
                if (tx_start && !busy) begin
                    level_s = nrzi_bit ? LS_J : LS_K;
                    oe_s    = 1'b1;
                    busy_s  = 1'b1;
`ifdef LINE_DRIVER_TIMEOUT_EN
                    bit_cnt_s = BCW'(1);
                    timeout_s = !tx_last && (BIT_LIMIT == BCW'(1));
`endif
                    if (tx_last || timeout_s) begin
                        state_s = EOP_SE0;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                level_s = nrzi_bit ? LS_J : LS_K;
                oe_s    = 1'b1;
                busy_s  = 1'b1;
`ifdef LINE_DRIVER_TIMEOUT_EN
                bit_cnt_s = bit_cnt + BCW'(1);
                timeout_s = !tx_last && (bit_cnt_s == BIT_LIMIT);
`endif
                if (tx_last || timeout_s) begin
                    state_s = EOP_SE0;
                end else begin
                    state_s = DATA;
                end
            end
            EOP_SE0: begin
                level_s = LS_SE0;
                oe_s    = 1'b1;
                busy_s  = 1'b1;
                if (eop_cnt == EOP_LAST) begin
                    eop_cnt_s = {ECW{1'b0}};
                    state_s   = EOP_J;
                end else begin
                    eop_cnt_s = eop_cnt + ECW'(1);
                    state_s   = EOP_SE0;
                end
            end
            EOP_J: begin
                level_s    = LS_J;
                oe_s       = 1'b1;
                busy_s     = 1'b1;
                eop_done_s = 1'b1;
                state_s    = IDLE;
            end
            default: begin
                eop_cnt_s = {ECW{1'b0}};
                state_s   = IDLE;
            end
        endcase
    end

    // State, EOP counter and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            eop_cnt  <= {ECW{1'b0}};
            dp       <= 1'b1;
            dm       <= 1'b0;
            oe       <= 1'b0;
            busy     <= 1'b0;
            eop_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            eop_cnt    <= eop_cnt_s;
            {dp, dm}   <= encode_level(level_s);
            oe         <= oe_s;
            busy       <= busy_s;
            eop_done   <= eop_done_s;
        end
    end

`ifdef LINE_DRIVER_TIMEOUT_EN
    // Packet length counter and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt     <= {BCW{1'b0}};
            timeout_err <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt_s;
            timeout_err <= timeout_err | timeout_s;
        end
    end
`endif

endmodule

// File: tb/tb_usb_line_driver.sv
// Scoreboard bench for usb_line_driver: per-cycle expected line state from a
// packet-level model, checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_usb_line_driver;

    localparam int E = 2;
`ifdef LINE_DRIVER_TIMEOUT_EN
    localparam int MAXB = 8;
    localparam bit WD   = 1'b1;
`else
    localparam int MAXB = 128;
    localparam bit WD   = 1'b0;
`endif

    typedef struct packed {
        logic dp;
        logic dm;
        logic oe;
        logic busy;
        logic eop_done;
        logic terr;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic nrzi_bit = 1'b0;
    logic tx_start = 1'b0;
    logic tx_last = 1'b0;
    logic dp, dm, oe, busy, eop_done, terr_dut;

    obs_t exp_q[$];
    obs_t tail[$];
    bit   m_in_pkt;
    bit   m_prev_busy;
    bit   m_terr;
    int   m_nbits;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_cyc = 0;

    always #5 clk = ~clk;

    usb_line_driver #(
        .EOP_SE0_BITS(E),
        .MAX_PKT_BITS(MAXB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .nrzi_bit(nrzi_bit),
        .tx_start(tx_start),
        .tx_last(tx_last),
        .dp(dp),
        .dm(dm),
        .oe(oe),
        .busy(busy),
        .eop_done(eop_done)
`ifdef LINE_DRIVER_TIMEOUT_EN
        ,
        .timeout_err(terr_dut)
`endif
    );

`ifndef LINE_DRIVER_TIMEOUT_EN
    assign terr_dut = 1'b0;
`endif

    function automatic obs_t mk(input logic p, input logic m, input logic o,
                                input logic b, input logic d);
        obs_t r;
        r.dp = p; r.dm = m; r.oe = o; r.busy = b; r.eop_done = d; r.terr = 1'b0;
        return r;
    endfunction

    // Expected line state after the coming edge, given this cycle's inputs.
    function automatic obs_t model_step(input logic r, input logic b,
                                        input logic s, input logic l);
        obs_t e;
        bit   wd;
        if (!r) begin
            m_in_pkt = 1'b0;
            tail.delete();
            m_terr = 1'b0;
            e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (tail.size() > 0) begin
            e = tail.pop_front();
        end else if (m_in_pkt || (s && !m_prev_busy)) begin
            if (!m_in_pkt) m_nbits = 0;
            m_in_pkt = 1'b1;
            m_nbits++;
            wd = WD && !l && (m_nbits == MAXB);
            if (wd) m_terr = 1'b1;
            e = mk(b, ~b, 1'b1, 1'b1, 1'b0);
            if (l || wd) begin
                m_in_pkt = 1'b0;
                for (int k = 0; k < E; k++) tail.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
                tail.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
            end
        end else begin
            e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        e.terr = m_terr;
        m_prev_busy = e.busy;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic b, input logic s, input logic l);
        obs_t e;
        @(negedge clk);
        rst_n = r; nrzi_bit = b; tx_start = s; tx_last = l;
        e = model_step(r, b, s, l);
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    endtask

    // Packet of len bits (LSB first); rst_at < len pulls reset on that bit.
    task automatic pkt(input int len, input logic [31:0] bits, input int rst_at);
        for (int i = 0; i < len; i++)
            cyc((i == rst_at) ? 1'b0 : 1'b1, bits[i], (i == 0), (i == len - 1));
    endtask

    // Monitor: compare the DUT line state with the oldest expectation.
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        n_cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dp, dm, oe, busy, eop_done, terr_dut};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL line@cyc%0d dp/dm/oe/busy/eop_done/terr got %b required %b",
                         n_cyc, a, e);
            end
        end
    end

    initial begin
        logic [15:0] pat;
        logic [31:0] v;
        int          len;
        int          ra;

        m_in_pkt = 1'b0; m_prev_busy = 1'b0; m_terr = 1'b0; m_nbits = 0;

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        idle(5);

        pat = 16'b0101_0100_1110_0001;
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = pat[15 - i];
        pkt(16, v, 99);
        idle(6);

        pkt(1, 32'h0000_0000, 99);
        idle(6);

        pkt(4, 32'h0000_0005, 99);
        idle(2);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(1);
        pkt(5, 32'h0000_0013, 99);
        idle(6);

        pkt(10, 32'h0000_02A5, 5);
        idle(8);

        pkt(12, 32'h0000_0F0F, 99);
        pkt(3, 32'h0000_0002, 99);
        idle(6);

        for (int p = 0; p < 250; p++) begin
            len = $urandom_range(20, 1);
            v   = $urandom;
            ra  = ($urandom_range(19) == 0) ? int'($urandom_range(len - 1)) : 99;
            pkt(len, v, ra);
            for (int g = $urandom_range(6); g > 0; g--)
                cyc(1'b1, 1'($urandom_range(1)),
                    ($urandom_range(9) == 0), ($urandom_range(4) == 0));
        end

        idle(12);
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got %0d required 0", exp_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
